// File: rtl/fft_stage_seq.sv
// rtl/fft_stage_seq.sv - control sequencer for one radix-2 delay-line FFT stage
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   ce                clock enable; when low every flop and output holds
//   valid_i, sof_i    input sample strobe and frame-start marker
//   ready_o           samples accepted (low only while draining the delay line)
//   valid_o           registered datapath-advance strobe
//   sel_o             0 = fill delay line, 1 = butterfly/twiddle phase
//   tw_idx_o          twiddle ROM index
//   drain_o           flush cycle with no new input
//   sof_o, eof_o      frame start/end markers aligned with valid_o
//   err_o             one-cycle protocol error pulse
//   inv_o             constant INVERSE (forward/inverse select for the datapath)
module fft_stage_seq #(
  parameter int LOG2N   = 4,
  parameter int STAGE   = 0,
  parameter int INVERSE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce,
  input  logic             valid_i,
  input  logic             sof_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic             sel_o,
  output logic [LOG2N-2:0] tw_idx_o,
  output logic             drain_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             err_o,
  output logic             inv_o
);

  localparam int N  = 1 << LOG2N;
  localparam int HB = LOG2N - 1 - STAGE;  // position bit that selects the butterfly half
  localparam int H  = 1 << HB;            // half-span of this stage
  localparam int DW = HB + 1;
  localparam int TW = LOG2N - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [LOG2N-1:0] LAST_POS = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] H_MASK   = LOG2N'(H - 1);
  localparam logic [DW-1:0]    LAST_D   = DW'(H - 1);

  logic [1:0]       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             valid_q, valid_d;
  logic             sel_q, sel_d;
  logic [TW-1:0]    tw_q, tw_d;
  logic             drain_q, drain_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             err_q, err_d;
  logic [LOG2N-1:0] pos;

  assign ready_o = (state_q != ST_DRAIN);

  // A sof_i sample always restarts the frame, so its position is 0 regardless of cnt.
  assign pos = (state_q == ST_RUN && !sof_i) ? cnt_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    tw_d    = tw_q;
    drain_d = drain_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    err_d   = err_q;
    if (ce) begin
      // Strobes are single-cycle; sel/tw keep their last value on idle cycles.
      valid_d = 1'b0;
      drain_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (valid_i) begin
            if (state_q == ST_IDLE && !sof_i) begin
              err_d = 1'b1;  // sample outside a frame is dropped
            end else begin
              err_d   = sof_i && (state_q == ST_RUN) && (cnt_q != '0);
              valid_d = 1'b1;
              sel_d   = pos[HB];
              tw_d    = pos[HB] ? TW'((pos & H_MASK) << STAGE) : '0;
              sof_d   = (pos == '0);
              eof_d   = (pos == LAST_POS);
              if (pos == LAST_POS) begin
                state_d = ST_DRAIN;
                cnt_d   = '0;
                dcnt_d  = '0;
              end else begin
                state_d = ST_RUN;
                cnt_d   = pos + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          valid_d = 1'b1;
          drain_d = 1'b1;
          sel_d   = 1'b1;
          tw_d    = '0;
          if (dcnt_q == LAST_D) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      tw_q    <= '0;
      drain_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      tw_q    <= tw_d;
      drain_q <= drain_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
    end
  end

  assign valid_o  = valid_q;
  assign sel_o    = sel_q;
  assign tw_idx_o = tw_q;
  assign drain_o  = drain_q;
  assign sof_o    = sof_q;
  assign eof_o    = eof_q;
  assign err_o    = err_q;
  assign inv_o    = (INVERSE != 0);

endmodule

// File: tb/tb_fft_stage_seq.sv
// tb/tb_fft_stage_seq.sv - bench for fft_stage_seq, stages 0 and 1 of an 8-point FFT
module tb_fft_stage_seq;

  localparam int LOG2N = 3;
  localparam int N     = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             ce = 1'b0;
  logic             valid_i = 1'b0;
  logic             sof_i = 1'b0;

  logic             ready0, valid0, sel0, drain0, sof0, eof0, err0, inv0;
  logic             ready1, valid1, sel1, drain1, sof1, eof1, err1, inv1;
  logic [LOG2N-2:0] tw0, tw1;

  always #5 CLK = ~CLK;

  fft_stage_seq #(.LOG2N(LOG2N), .STAGE(0), .INVERSE(0)) u_s0 (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .sof_i(sof_i),
    .ready_o(ready0), .valid_o(valid0), .sel_o(sel0), .tw_idx_o(tw0),
    .drain_o(drain0), .sof_o(sof0), .eof_o(eof0), .err_o(err0), .inv_o(inv0)
  );

  fft_stage_seq #(.LOG2N(LOG2N), .STAGE(1), .INVERSE(1)) u_s1 (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .sof_i(sof_i),
    .ready_o(ready1), .valid_o(valid1), .sel_o(sel1), .tw_idx_o(tw1),
    .drain_o(drain1), .sof_o(sof1), .eof_o(eof1), .err_o(err1), .inv_o(inv1)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model per stage k: next frame position (-1 = no frame open),
  // drain cycles still owed, and the expected registered outputs.
  int m_pos[2];
  int m_drn[2];
  int e_valid[2], e_sel[2], e_tw[2], e_drain[2], e_sof[2], e_eof[2], e_err[2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = -1; m_drn[k] = 0;
      e_valid[k] = 0; e_sel[k] = 0; e_tw[k] = 0; e_drain[k] = 0;
      e_sof[k] = 0; e_eof[k] = 0; e_err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic c, input logic v, input logic s);
    int h;
    int p;
    if (!c) return;
    h = (N / 2) >> k;  // half-span for STAGE=k
    e_valid[k] = 0; e_sof[k] = 0; e_eof[k] = 0; e_drain[k] = 0; e_err[k] = 0;
    if (m_drn[k] > 0) begin
      e_valid[k] = 1; e_drain[k] = 1; e_sel[k] = 1; e_tw[k] = 0;
      m_drn[k]--;
      return;
    end
    if (!v) return;
    if (!s && m_pos[k] < 0) begin
      e_err[k] = 1;
      return;
    end
    if (s) begin
      e_err[k] = (m_pos[k] > 0) ? 1 : 0;
      p = 0;
    end else begin
      p = m_pos[k];
    end
    e_valid[k] = 1;
    e_sel[k]   = (p / h) % 2;
    e_tw[k]    = (e_sel[k] == 1) ? ((p % h) * (1 << k)) % (N / 2) : 0;
    e_sof[k]   = (p == 0) ? 1 : 0;
    e_eof[k]   = (p == N - 1) ? 1 : 0;
    if (p == N - 1) begin
      m_pos[k] = -1;
      m_drn[k] = h;
    end else begin
      m_pos[k] = p + 1;
    end
  endtask

  task automatic check_one(input int k, input logic r, input logic v, input logic sl,
                           input logic [LOG2N-2:0] tw, input logic dr, input logic so,
                           input logic eo, input logic er);
    string pfx;
    pfx = $sformatf("s%0d", k);
    chk({pfx, ".ready"}, int'(r), (m_drn[k] == 0) ? 1 : 0);
    chk({pfx, ".valid"}, int'(v), e_valid[k]);
    chk({pfx, ".sel"}, int'(sl), e_sel[k]);
    chk({pfx, ".tw_idx"}, int'(tw), e_tw[k]);
    chk({pfx, ".drain"}, int'(dr), e_drain[k]);
    chk({pfx, ".sof"}, int'(so), e_sof[k]);
    chk({pfx, ".eof"}, int'(eo), e_eof[k]);
    chk({pfx, ".err"}, int'(er), e_err[k]);
  endtask

  task automatic check_all();
    check_one(0, ready0, valid0, sel0, tw0, drain0, sof0, eof0, err0);
    check_one(1, ready1, valid1, sel1, tw1, drain1, sof1, eof1, err1);
  endtask

  task automatic cycle(input logic c, input logic v, input logic s);
    ce = c; valid_i = v; sof_i = s;
    for (int k = 0; k < 2; k++) model_step(k, c, v, s);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  // Reset is asserted between edges so its asynchronous effect is observed directly.
  task automatic do_reset();
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    RST = 1'b1;
  endtask

  task automatic frame(input int gap_at);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < N; i++) begin
      if (i == gap_at) for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    chk("s0.inv", int'(inv0), 0);
    chk("s1.inv", int'(inv1), 1);
    RST = 1'b1;

    // sample without sof_i while idle
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // clean frame, then one with a 3-cycle ce stall mid-frame
    frame(-1);
    frame(3);

    // sof_i on the 5th sample restarts the frame
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    frame(-1);

    // reset while both stages are draining
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < N; i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    frame(-1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic c, v, s;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        c = ($urandom_range(0, 7) != 0);
        v = ($urandom_range(0, 3) != 0);
        s = (m_pos[0] < 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0);
        cycle(c, v, s);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_stage_seq.md
FFT_STAGE_SEQ -- requirements
Module: fft_stage_seq

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of FFT frame length N (legal 2..10).
REQ-002 SHALL have parameter STAGE, default 0, meaning the stage index (legal 0..LOG2N-1); half-span H = 2^(LOG2N-1-STAGE).
REQ-003 SHALL have parameter INVERSE, default 0, meaning forward (0) or inverse (1) transform; passed through on inv_o.
REQ-004 SHALL have port CLK  input  1  clock, rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ce  input  1  clock enable; when low all state and outputs hold.
REQ-007 SHALL have port valid_i  input  1  input sample strobe.
REQ-008 SHALL have port sof_i  input  1  first sample of frame, qualified by valid_i.
REQ-009 SHALL have port ready_o  output  1  block accepts samples (combinational from state).
REQ-010 SHALL have port valid_o  output  1  registered datapath-advance strobe.
REQ-011 SHALL have port sel_o  output  1  0 = fill delay line, 1 = butterfly/twiddle phase.
REQ-012 SHALL have port tw_idx_o  output  LOG2N-1  twiddle ROM index.
REQ-013 SHALL have port drain_o  output  1  flush cycle (no new input).
REQ-014 SHALL have port sof_o, eof_o  output  1 each  frame start/end markers aligned with valid_o.
REQ-015 SHALL have port err_o  output  1  one-cycle protocol error pulse.
REQ-016 SHALL have port inv_o  output  1  constant INVERSE.

Function
REQ-017 SHALL define accept = ce & valid_i & ready_o; ready_o = 1 in IDLE and RUN, 0 in DRAIN.
REQ-018 SHALL implement states IDLE, RUN, DRAIN and a LOG2N-bit sample counter cnt, plus a drain counter dcnt of LOG2N-1-STAGE+1 bits.
REQ-019 IDLE: accept with sof_i -> RUN, cnt=1; accept without sof_i -> sample dropped, err_o pulses, stay IDLE.
REQ-020 RUN: each accept increments cnt; accept at cnt=N-1 -> DRAIN, dcnt=0, cnt=0.
REQ-021 RUN: accept with sof_i while cnt!=0 -> err_o pulses, sample treated as new frame start (cnt=1, sof_o asserted).
REQ-022 DRAIN: each ce cycle increments dcnt; after H cycles (dcnt=H-1) -> IDLE; valid_i ignored, no error.
REQ-023 Outputs SHALL be registered, 1-cycle latency from the accepting/drain ce edge.
REQ-024 For accepted sample at position p (cnt before increment): valid_o=1, sel_o=bit (LOG2N-1-STAGE) of p, tw_idx_o=(p mod H) << STAGE when sel_o=1 else 0, sof_o=(p==0), eof_o=(p==N-1), drain_o=0.
REQ-025 For drain cycle d: valid_o=1, drain_o=1, sel_o=1, tw_idx_o=0, sof_o=eof_o=0.
REQ-026 Cycles with ce=1 and no accept/drain SHALL drive valid_o=0, sof_o=eof_o=drain_o=err_o=0; sel_o and tw_idx_o hold.
REQ-027 tw_idx_o arithmetic SHALL be unsigned, truncated to LOG2N-1 bits.

Reset
REQ-028 On RST low: state=IDLE, cnt=0, dcnt=0, valid_o=sel_o=drain_o=sof_o=eof_o=err_o=0, tw_idx_o=0, asynchronously.
REQ-029 Reset mid-frame or mid-drain SHALL abandon the frame; first sample after release must carry sof_i.

Verification (LOG2N=3, STAGE=0, N=8, H=4)
REQ-030 Frame of 8 accepts, sof_i on first -> sel_o 0,0,0,0,1,1,1,1; tw_idx_o 0,0,0,0,0,1,2,3; sof_o on 1st, eof_o on 8th; then 4 drain_o cycles, ready_o low 4 cycles.
REQ-031 valid_i=1 with sof_i=0 in IDLE -> err_o one pulse, valid_o stays 0, state IDLE.
REQ-032 sof_i at 5th sample -> err_o pulse, sof_o on that output, counting restarts, sel_o 0.
REQ-033 ce low for 3 cycles mid-frame with valid_i high -> no outputs change, sequence resumes without gaps in tw_idx_o.
REQ-034 RST asserted during DRAIN -> all outputs 0 immediately, ready_o=1, next sof frame behaves as REQ-030.
REQ-035 STAGE=1 frame -> sel_o 0,0,1,1,0,0,1,1; tw_idx_o 0,0,0,2,0,0,0,2; 2 drain cycles.
